weight_loader: RTL and testbench
================================

# weight_loader

Writer-side companion to the per-neuron weight memories. It accepts a framed stream of weight words and converts each frame into sequential single-port writes (`wen`/`waddr`/`win`) into the weight memory of one selected neuron. The writes start at address 0 and increment by one per word. It sits between the configuration stream interface and the bank of weight memories of one layer, so weights can be reloaded at run time without re-synthesising the memory init files.

## Interface
- `numNeurons`, default 30: neurons (weight memories) in the layer; width of `wen`.
- `numWeight`, default 784: maximum weights per neuron; must be ≤ 2**addressWidth.
- `addressWidth`, default 10: weight memory address width; write address is `addressWidth+1` bits, matching the memory read port.
- `dataWidth`, default 16: weight word width.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rstn` in 1: synchronous, active-low reset.
- `in_valid` in 1: stream beat valid.
- `in_ready` out 1: stream beat ready; a beat transfers when `in_valid && in_ready`.
- `in_data` in 32: header word, or a weight in `[dataWidth-1:0]` (upper bits ignored).
- `in_last` in 1: final beat of a frame.
- `wen` out numNeurons: one-hot write enable; bit n writes neuron n's memory.
- `waddr` out addressWidth+1: write address.
- `win` out dataWidth: write data.
- `busy` out 1: high in LOAD or DRAIN.
- `done` out 1: one-cycle pulse on a successfully completed frame.
- `err` out 1: sticky error flag.
- `err_code` out 2: 1 = bad neuron index, 2 = bad count, 3 = length mismatch.

## Operation
- Frame format: beat 0 is the header, with `in_data[31:16]` = neuron index n and `in_data[15:0]` = weight count N. It is followed by N weight beats, and `in_last` is set on the Nth weight.
- FSM states: IDLE, LOAD, DRAIN.
- **IDLE**: waits for a header beat.
  - On a valid header, latch n and N, clear the address counter k to 0, clear `err`/`err_code`, and go to LOAD.
  - n ≥ numNeurons → `err`=1, code 1, go to DRAIN.
  - N = 0 or N > numWeight → `err`=1, code 2, go to DRAIN.
  - Header with `in_last`=1 → code 3, stay in IDLE. This check has priority over the DRAIN transitions, since the frame is already over.
- **LOAD**: each accepted beat issues one write, `wen`=one-hot(n), `waddr`=k, `win`=`in_data[dataWidth-1:0]`, then k increments.
  - Beat with k = N-1 and `in_last`=1 → `done` pulse, go to IDLE.
  - `in_last`=1 with k < N-1 (short frame) → the write still happens, `err`=1, code 3, no `done`, go to IDLE.
  - k = N-1 with `in_last`=0 (long frame) → the write happens, `err`=1, code 3, go to DRAIN.
- **DRAIN**: accepts and discards beats with no writes. Returns to IDLE on the beat with `in_last`=1.
- When a new header is accepted, `err` and `err_code` clear in the same cycle the header is accepted. Otherwise they hold until reset.
- k never exceeds N-1, so `waddr` never wraps and never exceeds numWeight-1.

## Timing
- Reset values of all outputs are 0: `in_ready`, `wen`, `waddr`, `win`, `busy`, `done`, `err`, `err_code`. The FSM resets to IDLE and k to 0.
- `in_ready` stays 0 in the reset cycle. It rises on the first clock edge with `rstn`=1 and then stays 1 in every state, so there is no backpressure.
- Header accepted at cycle T → `busy`=1 from T+1.
- Weight beat accepted at cycle t → `wen`/`waddr`/`win` valid for exactly cycle t+1, registered. `wen` is 0 in every cycle without a write.
- `done` is high in the same cycle as the final write (t+1 of the last beat).
- `err` and `err_code` update one cycle after the offending beat.
- `busy` drops in the cycle after the beat that ends the frame.
- Throughput is one write per clock with back-to-back beats. A new header may follow the last beat in the very next cycle.
- Reset mid-frame: the write pending from the previous beat is cancelled (`wen`=0 on the reset cycle). The FSM returns to IDLE and the remaining frame beats after reset are treated as headers.

## Test plan
- **Nominal frame:** header n=3, N=4 with data 0x0011..0x0014 back-to-back → `wen`=1<<3 for 4 cycles, `waddr` 0,1,2,3, `win` 0x0011..0x0014, `done` with the 4th write, `err`=0.
- **Full-depth frame:** N=784 to neuron 29 with `in_valid` gaps → 784 writes, last `waddr`=783, a single `done`; a model memory matches the stream.
- **Bad header:** n=30 with N=5 → `err_code`=1, zero writes, 5 beats drained. Then a good frame follows → `err` clears on its header and the frame loads normally.
- **Short frame:** N=4, `in_last` on the 2nd weight → 2 writes, `err_code`=3, no `done`, IDLE. **Long frame:** N=2 with 4 weights → 2 writes, code 3, the remaining 2 beats drained.
- **Count limits:** N=0 → code 2. N=785 → code 2. Header with `in_last`=1 and N=1 → code 3, remains IDLE, zero writes.
- **Reset mid-frame:** `rstn`=0 after the 2nd of 4 weights → all outputs 0, no further writes. The next header after reset loads correctly.

Source files
------------

// File: rtl/weight_loader.sv
// Converts a framed weight stream (header + N weights) into sequential
// single-port writes into the weight memory of one selected neuron.
module weight_loader #(
    parameter int numNeurons   = 30,
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    input  logic                  in_last,
    output logic [numNeurons-1:0] wen,
    output logic [addressWidth:0] waddr,
    output logic [dataWidth-1:0]  win,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    localparam logic [addressWidth:0]  K_ONE       = 1;
    localparam logic [numNeurons-1:0]  SEL_ONE     = 1;
    localparam logic [31:0]            NUM_NEURONS = numNeurons;
    localparam logic [31:0]            NUM_WEIGHT  = numWeight;

    state_t                state;
    logic [numNeurons-1:0] sel;
    logic [addressWidth:0] k;
    logic [addressWidth:0] last_k;

    logic        beat;
    logic [15:0] hdr_neuron;
    logic [15:0] hdr_count;
    logic        bad_neuron;
    logic        bad_count;

    assign beat       = in_valid && in_ready;
    assign hdr_neuron = in_data[31:16];
    assign hdr_count  = in_data[15:0];
    assign bad_neuron = {16'd0, hdr_neuron} >= NUM_NEURONS;
    assign bad_count  = (hdr_count == 16'd0) || ({16'd0, hdr_count} > NUM_WEIGHT);

    // last_k holds N-1 so the final-beat test is a single equality against k
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            wen      <= '0;
            waddr    <= '0;
            win      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            sel      <= '0;
            k        <= '0;
            last_k   <= '0;
        end else begin
            in_ready <= 1'b1;
            wen      <= '0;
            done     <= 1'b0;
            if (beat) begin
                case (state)
                    IDLE: begin
                        sel      <= SEL_ONE << hdr_neuron;
                        last_k   <= hdr_count[addressWidth:0] - K_ONE;
                        k        <= '0;
                        err      <= 1'b0;
                        err_code <= 2'd0;
                        if (in_last) begin
                            err      <= 1'b1;
                            err_code <= 2'd3;
                        end else if (bad_neuron) begin
                            err      <= 1'b1;
                            err_code <= 2'd1;
                            state    <= DRAIN;
                            busy     <= 1'b1;
                        end else if (bad_count) begin
                            err      <= 1'b1;
                            err_code <= 2'd2;
                            state    <= DRAIN;
                            busy     <= 1'b1;
                        end else begin
                            state <= LOAD;
                            busy  <= 1'b1;
                        end
                    end
                    LOAD: begin
                        wen   <= sel;
                        waddr <= k;
                        win   <= in_data[dataWidth-1:0];
                        if (k == last_k) begin
                            if (in_last) begin
                                done  <= 1'b1;
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                err      <= 1'b1;
                                err_code <= 2'd3;
                                state    <= DRAIN;
                            end
                        end else if (in_last) begin
                            err      <= 1'b1;
                            err_code <= 2'd3;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            k <= k + K_ONE;
                        end
                    end
                    DRAIN: begin
                        if (in_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: expected writes are queued as beats
// are driven and matched against every observed write.
module tb_weight_loader;

    localparam int NN = 30;
    localparam int NW = 784;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam logic [NN-1:0] ONE_HOT0 = 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_data = 32'd0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [NN-1:0] wen;
    logic [AW:0]   waddr;
    logic [DW-1:0] win;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    typedef struct packed {
        logic [NN-1:0] e_wen;
        logic [AW:0]   e_addr;
        logic [DW-1:0] e_data;
        logic          e_done;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  tests = 0;
    int  fails = 0;
    int  done_seen = 0;
    int  exp_done = 0;
    int  exp_code = 0;
    bit  mon_en = 1'b0;

    always #5 clk = ~clk;

    weight_loader #(
        .numNeurons(NN), .numWeight(NW), .addressWidth(AW), .dataWidth(DW)
    ) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .wen(wen), .waddr(waddr),
        .win(win), .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual %0h required %0h", tag, actual, expected);
        end
    endtask

    // Every observed write is matched in order against the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (done === 1'b1) done_seen++;
            if (wen !== '0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write", 64'(wen), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("wen", 64'(wen), 64'(mon_e.e_wen));
                    checkOutput("waddr", 64'(waddr), 64'(mon_e.e_addr));
                    checkOutput("win", 64'(win), 64'(mon_e.e_data));
                    checkOutput("done_with_write", 64'(done), 64'(mon_e.e_done));
                end
            end else if (done !== 1'b0) begin
                checkOutput("stray_done", 64'(done), 64'd0);
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // nbeats weights follow the header; nbeats == 0 puts in_last on the header
    task automatic applyStimulus(input int n, input int cnt, input int nbeats, input bit gaps, input bit ramp);
        bit          good;
        int          nwrites;
        logic [15:0] w;
        logic [15:0] upper;
        wr_t         item;
        good = (n < NN) && (cnt > 0) && (cnt <= NW);
        if (nbeats == 0)        exp_code = 3;
        else if (n >= NN)       exp_code = 1;
        else if (!good)         exp_code = 2;
        else if (nbeats != cnt) exp_code = 3;
        else                    exp_code = 0;
        drive_beat({16'(n), 16'(cnt)}, nbeats == 0);
        checkOutput("busy_after_header", 64'(busy), 64'(nbeats != 0));
        checkOutput("err_after_header", 64'(err), 64'((nbeats == 0) || !good));
        nwrites = good ? ((nbeats < cnt) ? nbeats : cnt) : 0;
        if (good && nbeats == cnt) exp_done++;
        for (int i = 0; i < nbeats; i++) begin
            w     = ramp ? 16'(16'h0011 + i) : 16'($urandom_range(0, 65535));
            upper = 16'($urandom);
            if (i < nwrites) begin
                item.e_wen  = ONE_HOT0 << n;
                item.e_addr = (AW+1)'(i);
                item.e_data = w;
                item.e_done = (i == cnt - 1) && (nbeats == cnt);
                exp_q.push_back(item);
            end
            if (gaps && $urandom_range(0, 3) == 0) idle_cycles(1);
            drive_beat({upper, w}, i == nbeats - 1);
        end
    endtask

    task automatic settle(input string name);
        idle_cycles(3);
        checkOutput({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        checkOutput({name, "_busy"}, 64'(busy), 64'd0);
        checkOutput({name, "_err"}, 64'(err), 64'(exp_code != 0));
        checkOutput({name, "_code"}, 64'(err_code), 64'(exp_code));
        checkOutput({name, "_done_count"}, 64'(done_seen), 64'(exp_done));
        exp_q.delete();
    endtask

    initial begin
        wr_t item;
        rstn = 1'b0;
        idle_cycles(3);
        mon_en = 1'b1;
        checkOutput("reset_outputs", 64'({in_ready, wen, waddr, win, busy, done, err, err_code}), 64'd0);
        rstn = 1'b1;
        idle_cycles(1);
        checkOutput("in_ready_after_reset", 64'(in_ready), 64'd1);

        // nominal frame, immediately followed by a second frame
        applyStimulus(3, 4, 4, 1'b0, 1'b1);
        applyStimulus(0, 3, 3, 1'b0, 1'b0);
        settle("nominal");

        applyStimulus(29, NW, NW, 1'b1, 1'b0);
        settle("full_depth");

        applyStimulus(30, 5, 5, 1'b0, 1'b0);
        settle("bad_neuron");
        applyStimulus(7, 3, 3, 1'b0, 1'b0);
        settle("after_bad");

        applyStimulus(2, 4, 2, 1'b0, 1'b0);
        settle("short_frame");
        applyStimulus(4, 2, 4, 1'b0, 1'b0);
        settle("long_frame");

        applyStimulus(1, 0, 1, 1'b0, 1'b0);
        settle("count_zero");
        applyStimulus(1, NW + 1, 3, 1'b0, 1'b0);
        settle("count_over");
        applyStimulus(1, 1, 0, 1'b0, 1'b0);
        settle("header_last");

        // reset lands while the third weight is presented
        drive_beat({16'd5, 16'd4}, 1'b0);
        for (int i = 0; i < 2; i++) begin
            item.e_wen  = ONE_HOT0 << 5;
            item.e_addr = (AW+1)'(i);
            item.e_data = 16'(16'h0A00 + i);
            item.e_done = 1'b0;
            exp_q.push_back(item);
            drive_beat({16'hBEEF, 16'(16'h0A00 + i)}, 1'b0);
        end
        rstn     = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h0000_0A02;
        idle_cycles(1);
        checkOutput("reset_midframe_outputs",
                    64'({in_ready, wen, waddr, win, busy, done, err, err_code}), 64'd0);
        in_data = 32'h0000_0A03;
        in_last = 1'b1;
        idle_cycles(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rstn     = 1'b1;
        idle_cycles(1);
        checkOutput("in_ready_after_midreset", 64'(in_ready), 64'd1);
        exp_code = 0;
        settle("reset_midframe");

        applyStimulus(5, 4, 4, 1'b0, 1'b0);
        settle("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
